// File: rtl/compute_request_arbiter.sv
// Round-robin responder that shares one compute unit among NUM_REQ requesters.
// Issues one operation at a time and returns result/timeout status to the winner only.
package accel_pkg;
  typedef enum logic [1:0] {
    COMP_ADD = 2'd0,
    COMP_SUB = 2'd1,
    COMP_MUL = 2'd2,
    COMP_DOT = 2'd3
  } comp_type_e;

  typedef logic [63:0] matrix_t;
  typedef logic [31:0] vector_t;
endpackage

module compute_request_arbiter
  import accel_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 256,
  parameter  int CNT_WIDTH      = 16,
  localparam int GW             = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  comp_type_e           req_type [NUM_REQ],
  input  matrix_t              req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic                 rsp_error,
  output vector_t              rsp_data,
  output logic                 cu_request,
  input  logic                 cu_ready,
  input  logic                 cu_done,
  output comp_type_e           cu_comp_type,
  output matrix_t              cu_data,
  input  vector_t              cu_result,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic [CNT_WIDTH-1:0] timeout_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        ptr_q, grant_q;
  comp_type_e           cu_type_q;
  matrix_t              cu_data_q;
  logic [CW-1:0]        wait_cnt_q;
  vector_t              rsp_data_q;
  logic                 rsp_err_q;
  logic [CNT_WIDTH-1:0] tmo_cnt_q;

  logic                 rr_found;
  logic [GW-1:0]        rr_idx, rr_cand;
  logic [GW:0]          rr_sum;
  logic                 wait_expired;

  // Search ptr, ptr+1, ... wrapping at NUM_REQ; the sum never exceeds 2*NUM_REQ-2.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    rr_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_sum = {1'b0, ptr_q} + (GW+1)'(i);
      if (rr_sum >= (GW+1)'(NUM_REQ)) rr_sum = rr_sum - (GW+1)'(NUM_REQ);
      rr_cand = rr_sum[GW-1:0];
      if (!rr_found && req_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign wait_expired = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rr_found) state_d = S_ISSUE;
      S_ISSUE: if (cu_ready) state_d = S_WAIT;
      S_WAIT:  if (cu_done || wait_expired) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    cu_request = 1'b0;
    case (state_q)
      S_IDLE:  if (rr_found) req_ready[rr_idx] = 1'b1;
      S_ISSUE: cu_request = 1'b1;
      S_RESP:  rsp_valid[grant_q] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      grant_q    <= '0;
      cu_type_q  <= COMP_ADD;
      cu_data_q  <= '0;
      wait_cnt_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rr_found) begin
            grant_q   <= rr_idx;
            cu_type_q <= req_type[rr_idx];
            cu_data_q <= req_data[rr_idx];
          end
        end
        S_ISSUE: wait_cnt_q <= '0;
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          // A result arriving on the last allowed cycle still counts as success.
          if (cu_done) begin
            rsp_data_q <= cu_result;
            rsp_err_q  <= 1'b0;
          end else if (wait_expired) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        S_RESP: ptr_q <= (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign grant_id      = grant_q;
  assign cu_comp_type  = cu_type_q;
  assign cu_data       = cu_data_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_error     = rsp_err_q;
  assign timeout_count = tmo_cnt_q;

endmodule

// File: tb/tb_compute_request_arbiter.sv
// Self-checking bench: directed scenarios plus randomized transactions checked against
// a transaction-level model of round-robin order, handshake timing and timeout rules.
module tb_compute_request_arbiter;
  import accel_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TMO     = 8;
  localparam int CW      = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req_valid, req_ready, rsp_valid;
  comp_type_e         req_type [NUM_REQ];
  matrix_t            req_data [NUM_REQ];
  logic               rsp_error;
  vector_t            rsp_data;
  logic               cu_request, cu_ready, cu_done;
  comp_type_e         cu_comp_type;
  matrix_t            cu_data;
  vector_t            cu_result;
  logic               busy;
  logic [1:0]         grant_id;
  logic [CW-1:0]      timeout_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int      m_ptr;
  int      m_tmo;
  vector_t m_rsp_data;
  logic    m_rsp_err;

  compute_request_arbiter #(
    .NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_type(req_type), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
    .rsp_data(rsp_data), .cu_request(cu_request), .cu_ready(cu_ready),
    .cu_done(cu_done), .cu_comp_type(cu_comp_type), .cu_data(cu_data),
    .cu_result(cu_result), .busy(busy), .grant_id(grant_id),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_winner(input int ptr, input logic [NUM_REQ-1:0] mask);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic load_operands();
    for (int u = 0; u < NUM_REQ; u++) begin
      req_type[u] = comp_type_e'(2'($urandom_range(0, 3)));
      req_data[u] = {$urandom(), $urandom()};
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     64'(busy), 64'(0));
    check({tag, "_ready"},    64'(req_ready), 64'(0));
    check({tag, "_rspv"},     64'(rsp_valid), 64'(0));
    check({tag, "_rsperr"},   64'(rsp_error), 64'(0));
    check({tag, "_rspdata"},  64'(rsp_data), 64'(0));
    check({tag, "_cureq"},    64'(cu_request), 64'(0));
    check({tag, "_cutype"},   64'(cu_comp_type), 64'(COMP_ADD));
    check({tag, "_cudata"},   64'(cu_data), 64'(0));
    check({tag, "_grant"},    64'(grant_id), 64'(0));
    check({tag, "_tmocnt"},   64'(timeout_count), 64'(0));
  endtask

  // Asserts rst between clock edges, checks outputs before any edge, then releases.
  task automatic do_reset(input string tag);
    @(negedge clk);
    req_valid = '0; cu_ready = 1'b0; cu_done = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_tmo = 0; m_rsp_data = '0; m_rsp_err = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit stray_done);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = '0; cu_ready = 1'b0;
      cu_done = stray_done; cu_result = vector_t'($urandom());
      #1;
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_rspv", 64'(rsp_valid), 64'(0));
      check("idle_ready", 64'(req_ready), 64'(0));
      check("idle_rsphold", 64'(rsp_data), 64'(m_rsp_data));
    end
    cu_done = 1'b0;
  endtask

  // One transaction: mask held throughout, bp cycles of cu_ready=0 in ISSUE,
  // cu_done on WAIT cycle dly (dly >= TMO means it never comes).
  task automatic do_txn(input logic [NUM_REQ-1:0] mask, input int bp, input int dly,
                        input vector_t res);
    int                 g;
    logic [NUM_REQ-1:0] onehot;
    matrix_t            d;
    comp_type_e         t;
    bit                 done_seen;
    @(negedge clk);
    req_valid = mask; cu_ready = 1'b0; cu_done = 1'b0;
    load_operands();
    #1;
    g      = rr_winner(m_ptr, mask);
    onehot = NUM_REQ'(1 << g);
    d      = req_data[g];
    t      = req_type[g];
    check("req_ready", 64'(req_ready), 64'(onehot));
    check("accept_busy", 64'(busy), 64'(0));
    check("accept_rspv", 64'(rsp_valid), 64'(0));
    check("rsp_hold", 64'(rsp_data), 64'(m_rsp_data));
    check("err_hold", 64'(rsp_error), 64'(m_rsp_err));
    for (int k = 0; k <= bp; k++) begin
      @(negedge clk);
      cu_ready = (k == bp);
      load_operands();
      #1;
      check("cu_request", 64'(cu_request), 64'(1));
      check("cu_data", 64'(cu_data), 64'(d));
      check("cu_type", 64'(cu_comp_type), 64'(t));
      check("grant_id", 64'(grant_id), 64'(g));
      check("issue_ready", 64'(req_ready), 64'(0));
    end
    done_seen = (dly < TMO);
    for (int w = 0; w < TMO; w++) begin
      @(negedge clk);
      cu_ready  = 1'b0;
      cu_done   = (w == dly);
      cu_result = (w == dly) ? res : vector_t'($urandom());
      #1;
      check("wait_request", 64'(cu_request), 64'(0));
      check("wait_rspv", 64'(rsp_valid), 64'(0));
      check("wait_busy", 64'(busy), 64'(1));
      if (w == dly) break;
    end
    @(negedge clk);
    cu_done   = 1'(($urandom() & 1));
    cu_result = vector_t'($urandom());
    #1;
    if (done_seen) begin
      m_rsp_data = res; m_rsp_err = 1'b0;
    end else begin
      m_rsp_data = '0; m_rsp_err = 1'b1;
      if (m_tmo < (1 << CW) - 1) m_tmo++;
    end
    check("rsp_valid", 64'(rsp_valid), 64'(onehot));
    check("rsp_error", 64'(rsp_error), 64'(m_rsp_err));
    check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
    check("timeout_count", 64'(timeout_count), 64'(m_tmo));
    m_ptr = (g + 1) % NUM_REQ;
    cu_done = 1'b0;
  endtask

  initial begin
    int fair_seq [6] = '{0, 1, 2, 3, 0, 1};
    rst = 1'b0; req_valid = '0; cu_ready = 1'b0; cu_done = 1'b0; cu_result = '0;
    load_operands();

    // Reset with no clock edge, then a quiet idle period
    #2 rst = 1'b1;
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_tmo = 0; m_rsp_data = '0; m_rsp_err = 1'b0;
    idle_cycles(10, 1'b0);

    // Single request from unit 2, result on the third WAIT cycle
    do_txn(4'b0100, 0, 2, 32'h0000_ABCD);
    idle_cycles(1, 1'b0);

    // Fairness with all units requesting from reset
    do_reset("rst_fair");
    for (int i = 0; i < 6; i++) begin
      do_txn(4'b1111, i % 3, i % 4, vector_t'($urandom()));
      check("fair_order", 64'(grant_id), 64'(fair_seq[i]));
    end

    // Backpressure: five cycles of cu_ready=0
    do_txn(4'b0001, 5, 1, 32'h1234_5678);

    // Timeout, then a late cu_done in IDLE must be ignored
    do_txn(4'b0010, 0, TMO + 5, 32'hDEAD_BEEF);
    idle_cycles(3, 1'b1);
    // cu_done on the final allowed WAIT cycle wins over timeout
    do_txn(4'b0100, 1, TMO - 1, 32'h0BAD_F00D);

    // Reset while waiting on unit 3
    do_reset("rst_pre");
    @(negedge clk);
    req_valid = 4'b1000; #1;
    check("r6_ready", 64'(req_ready), 64'(4'b1000));
    @(negedge clk); req_valid = '0; cu_ready = 1'b1;
    @(negedge clk); cu_ready = 1'b0;
    @(negedge clk); #1;
    check("r6_grant", 64'(grant_id), 64'(3));
    check("r6_busy", 64'(busy), 64'(1));
    do_reset("rst_wait");
    idle_cycles(2, 1'b0);
    do_txn(4'b1010, 0, 0, 32'h0000_0001);
    do_txn(4'b1010, 0, 0, 32'h0000_0003);

    // Randomized transactions with occasional idle gaps and stray strobes
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), 1'($urandom() & 1));
      do_txn(NUM_REQ'($urandom_range(1, 15)), $urandom_range(0, 3),
             $urandom_range(0, TMO + 2), vector_t'($urandom()));
    end
    idle_cycles(2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
